// File: rtl/serial_mag_comparator_pkg.sv
// Shared encodings for the serial magnitude comparator: FSM states and the
// {less, greater, equal} cascade codes passed between comparator slices.
package serial_mag_comparator_pkg;

    localparam logic StIdle = 1'b0;
    localparam logic StRun  = 1'b1;

    localparam logic [2:0] CascNoDec = 3'b000;
    localparam logic [2:0] CascLt    = 3'b100;
    localparam logic [2:0] CascGt    = 3'b010;
    localparam logic [2:0] CascEq    = 3'b001;

endpackage

// File: rtl/comparator_2bit.sv
// Cascadable 2-bit unsigned magnitude comparator slice. An upstream less or
// greater decision wins; otherwise the slice decides from its own bits.
module comparator_2bit
    import serial_mag_comparator_pkg::*;
(
    input  logic lin,
    input  logic gin,
    input  logic ein,
    output logic lout,
    output logic gout,
    output logic eout,
    input  logic x1,
    input  logic x0,
    input  logic y1,
    input  logic y0
);

    logic [1:0] xv;
    logic [1:0] yv;
    logic [2:0] code;

    assign xv = {x1, x0};
    assign yv = {y1, y0};

    // ein carries no information beyond "no decision yet", so equal bits
    // always resolve to equal once lin/gin are clear.
    always_comb begin
        code = CascEq;
        if (lin) begin
            code = CascLt;
        end else if (gin) begin
            code = CascGt;
        end else if (xv < yv) begin
            code = CascLt;
        end else if (xv > yv) begin
            code = CascGt;
        end else begin
            code = ein ? CascEq : CascEq;
        end
    end

    assign {lout, gout, eout} = code;

endmodule

// File: rtl/serial_mag_comparator.sv
// Sequential WIDTH-bit unsigned comparator: walks the operands MSB-first,
// two bits per cycle, through one cascaded comparator_2bit slice.
module serial_mag_comparator
    import serial_mag_comparator_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    localparam int unsigned STEPS = WIDTH / 2;
    localparam int unsigned CntW  = $clog2(STEPS) + 1;

    if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("serial_mag_comparator: WIDTH must be even and >= 2");
    end

    logic             state_q, state_d;
    logic [WIDTH-1:0] sx_q, sx_d;
    logic [WIDTH-1:0] sy_q, sy_d;
    logic [2:0]       casc_q, casc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [2:0]       res_q, res_d;
    logic             s_lout, s_gout, s_eout;

    comparator_2bit u_slice (
        .lin  (casc_q[2]),
        .gin  (casc_q[1]),
        .ein  (casc_q[0]),
        .lout (s_lout),
        .gout (s_gout),
        .eout (s_eout),
        .x1   (sx_q[WIDTH-1]),
        .x0   (sx_q[WIDTH-2]),
        .y1   (sy_q[WIDTH-1]),
        .y0   (sy_q[WIDTH-2])
    );

    always_comb begin
        state_d = state_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        casc_d  = casc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        done_d  = 1'b0;
        if (state_q == StIdle) begin
            if (start) begin
                state_d = StRun;
                sx_d    = x;
                sy_d    = y;
                casc_d  = CascNoDec;
                cnt_d   = '0;
            end
        end else begin
            casc_d = {s_lout, s_gout, s_eout};
            sx_d   = sx_q << 2;
            sy_d   = sy_q << 2;
            cnt_d  = cnt_q + CntW'(1);
            if (cnt_q == CntW'(STEPS - 1)) begin
                state_d = StIdle;
                res_d   = {s_lout, s_gout, s_eout};
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            sx_q    <= '0;
            sy_q    <= '0;
            casc_q  <= CascNoDec;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            res_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            casc_q  <= casc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            res_q   <= res_d;
        end
    end

    assign busy         = (state_q == StRun);
    assign done         = done_q;
    assign {lt, gt, eq} = res_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Self-checking bench for serial_mag_comparator (WIDTH=8): directed vector
// table, multi-cycle corner sequences and randomized compares against a model.
module tb_serial_mag_comparator;

    localparam int unsigned W     = 8;
    localparam int unsigned STEPS = W / 2;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         busy;
    logic         done;
    logic         lt;
    logic         gt;
    logic         eq;

    int n_cmp;
    int n_fail;
    logic [2:0] last_res;

    serial_mag_comparator #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .x       (x),
        .y       (y),
        .busy    (busy),
        .done    (done),
        .lt      (lt),
        .gt      (gt),
        .eq      (eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] vx;
        logic [W-1:0] vy;
        logic [2:0]   exp_res;
    } vec_t;

    // Reference: plain unsigned arithmetic, result as {lt, gt, eq}.
    function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a < b) return 3'b100;
        if (a > b) return 3'b010;
        return 3'b001;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One full compare from an idle DUT; checks busy/done timing every cycle.
    task automatic run_compare(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2:0] exp_res, input string tag);
        chk({tag, " idle busy"}, {7'd0, busy}, 8'd0);
        start = 1'b1;
        x     = a;
        y     = b;
        tick();
        start = 1'b0;
        x     = W'($urandom);
        y     = W'($urandom);
        for (int k = 1; k <= int'(STEPS); k++) begin
            if (k < int'(STEPS)) begin
                chk({tag, " busy"}, {7'd0, busy}, 8'd1);
                chk({tag, " done early"}, {7'd0, done}, 8'd0);
                chk({tag, " held result"}, {5'd0, lt, gt, eq}, {5'd0, last_res});
            end
            tick();
        end
        chk({tag, " done"}, {7'd0, done}, 8'd1);
        chk({tag, " busy end"}, {7'd0, busy}, 8'd0);
        chk({tag, " result"}, {5'd0, lt, gt, eq}, {5'd0, exp_res});
        last_res = exp_res;
        tick();
        chk({tag, " done width"}, {7'd0, done}, 8'd0);
    endtask

    vec_t vecs[$];

    initial begin
        int dones;
        logic [W-1:0] a;
        logic [W-1:0] b;
        n_cmp    = 0;
        n_fail   = 0;
        last_res = 3'b000;
        reset_n  = 1'b0;
        start    = 1'b0;
        x        = '0;
        y        = '0;

        vecs.push_back('{8'hA5, 8'hA5, 3'b001});
        vecs.push_back('{8'h80, 8'h7F, 3'b010});
        vecs.push_back('{8'h00, 8'h01, 3'b100});
        vecs.push_back('{8'hFF, 8'h00, 3'b010});
        vecs.push_back('{8'h00, 8'hFF, 3'b100});
        vecs.push_back('{8'h7F, 8'h80, 3'b100});
        vecs.push_back('{8'h00, 8'h00, 3'b001});
        vecs.push_back('{8'hFF, 8'hFF, 3'b001});
        vecs.push_back('{8'h5A, 8'h59, 3'b010});
        vecs.push_back('{8'h34, 8'h38, 3'b100});

        tick();
        tick();
        chk("reset busy", {7'd0, busy}, 8'd0);
        chk("reset done", {7'd0, done}, 8'd0);
        chk("reset result", {5'd0, lt, gt, eq}, 8'd0);
        start = 1'b1;
        tick();
        chk("reset overrides start", {7'd0, busy}, 8'd0);
        start   = 1'b0;
        reset_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            run_compare(vecs[i].vx, vecs[i].vy, vecs[i].exp_res, $sformatf("vec%0d", i));
        end

        // Back-to-back with start held through the done cycle.
        start = 1'b1;
        x     = 8'hFF;
        y     = 8'h00;
        tick();
        for (int k = 1; k < int'(STEPS); k++) tick();
        tick();
        chk("b2b first done", {7'd0, done}, 8'd1);
        chk("b2b first result", {5'd0, lt, gt, eq}, 8'b010);
        chk("b2b idle on done", {7'd0, busy}, 8'd0);
        x = 8'h00;
        y = 8'hFF;
        tick();
        start = 1'b0;
        chk("b2b accepted", {7'd0, busy}, 8'd1);
        chk("b2b held", {5'd0, lt, gt, eq}, 8'b010);
        dones = 0;
        for (int k = 0; k < int'(STEPS); k++) begin
            tick();
            if (done) dones++;
        end
        chk("b2b second done", {7'd0, done}, 8'd1);
        chk("b2b second result", {5'd0, lt, gt, eq}, 8'b100);
        chk("b2b single done", 8'(dones), 8'd1);
        last_res = 3'b100;
        tick();

        // start while busy is ignored.
        start = 1'b1;
        x     = 8'h10;
        y     = 8'h20;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        x     = 8'hF0;
        y     = 8'h00;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("busy-start done", {7'd0, done}, 8'd1);
        chk("busy-start result", {5'd0, lt, gt, eq}, 8'b100);
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done) dones++;
        end
        chk("busy-start no extra done", 8'(dones), 8'd0);
        chk("busy-start idle", {7'd0, busy}, 8'd0);

        // Reset mid-run aborts with no done pulse.
        start = 1'b1;
        x     = 8'h33;
        y     = 8'h30;
        tick();
        start = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        chk("abort busy", {7'd0, busy}, 8'd0);
        chk("abort done", {7'd0, done}, 8'd0);
        chk("abort result", {5'd0, lt, gt, eq}, 8'd0);
        reset_n = 1'b1;
        dones   = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done) dones++;
        end
        chk("abort no done", 8'(dones), 8'd0);
        last_res = 3'b000;
        run_compare(8'h33, 8'h30, 3'b010, "post-abort");

        // Randomized compares; bias toward shared upper groups to stress cascading.
        for (int i = 0; i < 150; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 2))
                0:       b = a;
                1:       b = a ^ W'(($urandom_range(1, 3)) << (2 * $urandom_range(0, STEPS - 1)));
                default: b = W'($urandom);
            endcase
            run_compare(a, b, model(a, b), $sformatf("rnd%0d", i));
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
